// File: rtl/clk_period_meter_if.sv
// Signal bundle between the slow-clock period meter and whoever drives/observes it.
// Scalar clk and rst stay outside the bundle.
interface clk_period_meter_if #(
    parameter int unsigned CNT_W = 22
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             in_tol;
    logic             timeout;

    modport master (
        output en,
        output sig_in,
        input  period_out,
        input  high_out,
        input  valid,
        input  in_tol,
        input  timeout
    );

    modport slave (
        input  en,
        input  sig_in,
        output period_out,
        output high_out,
        output valid,
        output in_tol,
        output timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// Receive-side checker for the divided slow clock: synchronizes it, measures high time
// and rise-to-rise period in clk cycles, checks both halves against a tolerance window.
module clk_period_meter #(
    parameter int unsigned CNT_W    = 22,
    parameter int unsigned EXP_HALF = 500000,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned TIMEOUT  = 1500000
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_period_meter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W:0]   EXP_W     = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W+1)'(TOL);

    // Window test in CNT_W+1 bits so neither side of the compare can wrap.
    function automatic logic half_ok(input logic [CNT_W:0] half);
        return ((half + TOL_W) >= EXP_W) && (half <= (EXP_W + TOL_W));
    endfunction

    logic             s1_q, s2_q, s3_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             in_tol_q, in_tol_d;
    logic             timeout_q, timeout_d;
    logic             rise_s, fall_s;
    logic [CNT_W:0]   low_s;

    assign rise_s = s2_q & ~s3_q;
    assign fall_s = ~s2_q & s3_q;
    assign low_s  = {1'b0, cnt_q} - {1'b0, high_q};

    // Next-state and output-update logic for the measurement FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        in_tol_d  = in_tol_q;
        timeout_d = timeout_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    timeout_d = 1'b0;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_d = ST_HIGH;
                        cnt_d   = ONE_C;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        high_d  = cnt_q;
                        cnt_d   = cnt_q + ONE_C;
                        state_d = ST_LOW;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        period_d = cnt_q;
                        in_tol_d = half_ok({1'b0, high_q}) && half_ok(low_s);
                        valid_d  = 1'b1;
                        cnt_d    = ONE_C;
                        state_d  = ST_HIGH;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            in_tol_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            s1_q      <= bus.sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            in_tol_q  <= in_tol_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.valid      = valid_q;
    assign bus.in_tol     = in_tol_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter: an event/timestamp reference model predicts
// every output on every cycle, plus spot checks of the nominal values.
module tb_clk_period_meter;

    localparam int CNT_W    = 8;
    localparam int EXP_HALF = 10;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_period_meter #(
        .CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    // Reference: phase 0 off, 1 waiting for first rise, 2 in high half, 3 in low half.
    int phase   = 0;
    int cyc     = 0;
    int rise_at = 0;
    bit d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
    int exp_period = 0, exp_high = 0;
    bit exp_valid = 1'b0, exp_tol = 1'b0, exp_to = 1'b0;
    bit prev_valid = 1'b0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit near(input int v);
        int d;
        d = (v > EXP_HALF) ? (v - EXP_HALF) : (EXP_HALF - v);
        return d <= TOL;
    endfunction

    task automatic model_edge();
        bit r, f;
        r = d2 && !d3;
        f = !d2 && d3;
        exp_valid = 1'b0;
        if (rst) begin
            d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
            phase = 0;
            exp_period = 0; exp_high = 0; exp_tol = 1'b0; exp_to = 1'b0;
        end else begin
            d3 = d2; d2 = d1; d1 = bus.sig_in;
            if (!bus.en) begin
                phase = 0;
            end else if (phase == 0) begin
                phase  = 1;
                exp_to = 1'b0;
            end else if (phase == 1) begin
                if (r) begin
                    phase   = 2;
                    rise_at = cyc;
                end
            end else if (phase == 2) begin
                if (f) begin
                    exp_high = cyc - rise_at;
                    phase    = 3;
                end else if (cyc - rise_at == TIMEOUT) begin
                    exp_to = 1'b1;
                    phase  = 1;
                end
            end else begin
                if (r) begin
                    exp_period = cyc - rise_at;
                    exp_tol    = near(exp_high) && near(exp_period - exp_high);
                    exp_valid  = 1'b1;
                    rise_at    = cyc;
                    phase      = 2;
                end else if (cyc - rise_at == TIMEOUT) begin
                    exp_to = 1'b1;
                    phase  = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_eq("valid",   longint'(bus.valid),      longint'(exp_valid));
        check_eq("period",  longint'(bus.period_out), longint'(exp_period));
        check_eq("high",    longint'(bus.high_out),   longint'(exp_high));
        check_eq("in_tol",  longint'(bus.in_tol),     longint'(exp_tol));
        check_eq("timeout", longint'(bus.timeout),    longint'(exp_to));
        if (prev_valid) begin
            check_eq("valid_twice", longint'(bus.valid), 0);
        end
        prev_valid = bus.valid;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sig_in = 1'b1;
            repeat (hi) step();
            bus.sig_in = 1'b0;
            repeat (lo) step();
        end
    endtask

    initial begin
        int hi, lo;
        bus.en     = 1'b1;
        bus.sig_in = 1'b0;
        rst        = 1'b1;

        // reset with the input toggling
        bus.sig_in = 1'b1; step();
        bus.sig_in = 1'b0; step();
        check_eq("rst_period", longint'(bus.period_out), 0);
        check_eq("rst_valid",  longint'(bus.valid), 0);
        rst = 1'b0;

        // nominal 10/10 square wave
        wave(10, 10, 5);
        check_eq("nom_period", longint'(bus.period_out), 20);
        check_eq("nom_high",   longint'(bus.high_out), 10);
        check_eq("nom_tol",    longint'(bus.in_tol), 1);

        // reset held mid-high
        bus.sig_in = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        check_eq("midrst_period", longint'(bus.period_out), 0);
        check_eq("midrst_high",   longint'(bus.high_out), 0);
        rst = 1'b0;
        repeat (5) step();
        bus.sig_in = 1'b0;
        repeat (10) step();

        // duty skew
        wave(11, 9, 3);
        check_eq("skew11_period", longint'(bus.period_out), 20);
        check_eq("skew11_high",   longint'(bus.high_out), 11);
        check_eq("skew11_tol",    longint'(bus.in_tol), 1);
        wave(12, 8, 3);
        check_eq("skew12_period", longint'(bus.period_out), 20);
        check_eq("skew12_tol",    longint'(bus.in_tol), 0);

        // stall, then recovery with sticky timeout
        wave(60, 10, 1);
        check_eq("stall_to", longint'(bus.timeout), 1);
        wave(10, 10, 4);
        check_eq("recover_period", longint'(bus.period_out), 20);
        check_eq("recover_to",     longint'(bus.timeout), 1);
        bus.en = 1'b0; step();
        bus.en = 1'b1; step(); step();
        check_eq("to_cleared", longint'(bus.timeout), 0);

        // enable dropped five cycles into the low half
        wave(10, 10, 3);
        bus.sig_in = 1'b1; repeat (10) step();
        bus.sig_in = 1'b0; repeat (5) step();
        bus.en = 1'b0; repeat (6) step();
        check_eq("endrop_period", longint'(bus.period_out), 20);
        bus.en = 1'b1;
        wave(9, 11, 3);

        // randomized halves with occasional stalls and enable drops
        for (int k = 0; k < 40; k++) begin
            hi = $urandom_range(6, 14);
            lo = $urandom_range(6, 14);
            if ($urandom_range(0, 9) == 0) hi = 55;
            wave(hi, lo, 1);
            if ($urandom_range(0, 7) == 0) begin
                bus.en = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                bus.en = 1'b1;
            end
        end
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
